// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline controller.
// Holds register-index width, FSM encoding and the control bundle.
package pipe_ctrl_pkg;

    localparam int REG_IDX_WIDTH = 5;

    typedef enum logic {
        PCTL_RUN      = 1'b0,
        PCTL_MDU_WAIT = 1'b1
    } pctl_state_e;

    typedef struct packed {
        logic mdu_start;
        logic if_stall;
        logic id_stall;
        logic ex_bubble;
        logic if_flush;
        logic id_flush;
        logic ex_mdu_wb;
    } pctl_ctrl_t;

    function automatic logic src_match(
        input logic                     en,
        input logic [REG_IDX_WIDTH-1:0] src,
        input logic [REG_IDX_WIDTH-1:0] dst
    );
        return en & (src == dst);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID/EX/MDU status in, per-stage pipeline controls out.
// master = pipeline side, slave = pipe_ctrl.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                     id_valid_i;
    logic                     id_rs1_en_i;
    logic                     id_rs2_en_i;
    logic [REG_IDX_WIDTH-1:0] id_rs1_idx_i;
    logic [REG_IDX_WIDTH-1:0] id_rs2_idx_i;
    logic                     ex_valid_i;
    logic                     ex_is_load_i;
    logic                     ex_is_mdu_i;
    logic [REG_IDX_WIDTH-1:0] ex_rd_idx_i;
    logic                     ex_pipe_flush_i;
    logic                     mdu_done_i;
    logic                     mdu_start_o;
    logic                     if_stall_o;
    logic                     id_stall_o;
    logic                     ex_bubble_o;
    logic                     if_flush_o;
    logic                     id_flush_o;
    logic                     ex_mdu_wb_o;

    modport master (
        output id_valid_i, id_rs1_en_i, id_rs2_en_i,
        output id_rs1_idx_i, id_rs2_idx_i,
        output ex_valid_i, ex_is_load_i, ex_is_mdu_i,
        output ex_rd_idx_i, ex_pipe_flush_i, mdu_done_i,
        input  mdu_start_o, if_stall_o, id_stall_o,
        input  ex_bubble_o, if_flush_o, id_flush_o,
        input  ex_mdu_wb_o
    );

    modport slave (
        input  id_valid_i, id_rs1_en_i, id_rs2_en_i,
        input  id_rs1_idx_i, id_rs2_idx_i,
        input  ex_valid_i, ex_is_load_i, ex_is_mdu_i,
        input  ex_rd_idx_i, ex_pipe_flush_i, mdu_done_i,
        output mdu_start_o, if_stall_o, id_stall_o,
        output ex_bubble_o, if_flush_o, id_flush_o,
        output ex_mdu_wb_o
    );

endinterface

// File: rtl/pctl_hazard.sv
// pctl_hazard: combinational load-use comparator between ID and EX.
// A load to x0 never creates a hazard since x0 is never written.
module pctl_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic                     i_id_valid,
    input  logic                     i_rs1_en,
    input  logic                     i_rs2_en,
    input  logic [REG_IDX_WIDTH-1:0] i_rs1_idx,
    input  logic [REG_IDX_WIDTH-1:0] i_rs2_idx,
    input  logic                     i_ex_valid,
    input  logic                     i_ex_is_load,
    input  logic [REG_IDX_WIDTH-1:0] i_rd_idx,
    output logic                     o_lu_hit
);

    logic w_ld_live;
    logic w_src_hit;

    assign w_ld_live = i_ex_valid & i_ex_is_load & (i_rd_idx != '0);

    assign w_src_hit = src_match(i_rs1_en, i_rs1_idx, i_rd_idx)
                     | src_match(i_rs2_en, i_rs2_idx, i_rd_idx);

    assign o_lu_hit = w_ld_live & i_id_valid & w_src_hit;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: EX sequencing around the MDU, load-use stalls, mispredict
// flushes, and free-running stall/flush performance counters.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_ctrl_if.slave       bus,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    import pipe_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pctl_state_e      r_state;
    pctl_state_e      w_next;
    pctl_ctrl_t       w_ctrl;
    logic             w_lu_hit;
    logic             w_flush;
    logic             w_mdu;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    pctl_hazard u_hazard (
        .i_id_valid   (bus.id_valid_i),
        .i_rs1_en     (bus.id_rs1_en_i),
        .i_rs2_en     (bus.id_rs2_en_i),
        .i_rs1_idx    (bus.id_rs1_idx_i),
        .i_rs2_idx    (bus.id_rs2_idx_i),
        .i_ex_valid   (bus.ex_valid_i),
        .i_ex_is_load (bus.ex_is_load_i),
        .i_rd_idx     (bus.ex_rd_idx_i),
        .o_lu_hit     (w_lu_hit)
    );

    assign w_flush = bus.ex_valid_i & bus.ex_pipe_flush_i;
    assign w_mdu   = bus.ex_valid_i & bus.ex_is_mdu_i;

    // Control decode; gated by rst_n so every control is quiet in reset.
    always_comb begin
        w_ctrl = '0;
        w_next = r_state;
        if (rst_n) begin
            unique case (r_state)
                PCTL_RUN: begin
                    if (w_flush) begin
                        w_ctrl.if_flush  = 1'b1;
                        w_ctrl.id_flush  = 1'b1;
                        w_ctrl.ex_bubble = 1'b1;
                    end else if (w_mdu) begin
                        w_ctrl.mdu_start = 1'b1;
                        w_ctrl.if_stall  = 1'b1;
                        w_ctrl.id_stall  = 1'b1;
                        w_next           = PCTL_MDU_WAIT;
                    end else if (w_lu_hit) begin
                        w_ctrl.if_stall  = 1'b1;
                        w_ctrl.id_stall  = 1'b1;
                        w_ctrl.ex_bubble = 1'b1;
                    end
                end
                PCTL_MDU_WAIT: begin
                    if (bus.mdu_done_i) begin
                        w_ctrl.ex_mdu_wb = 1'b1;
                        w_next           = PCTL_RUN;
                    end else begin
                        w_ctrl.if_stall  = 1'b1;
                        w_ctrl.id_stall  = 1'b1;
                    end
                end
                default: w_next = PCTL_RUN;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PCTL_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Performance counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_ctrl.if_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_ctrl.if_flush) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign bus.mdu_start_o = w_ctrl.mdu_start;
    assign bus.if_stall_o  = w_ctrl.if_stall;
    assign bus.id_stall_o  = w_ctrl.id_stall;
    assign bus.ex_bubble_o = w_ctrl.ex_bubble;
    assign bus.if_flush_o  = w_ctrl.if_flush;
    assign bus.id_flush_o  = w_ctrl.id_flush;
    assign bus.ex_mdu_wb_o = w_ctrl.ex_mdu_wb;
    assign stall_cnt_o     = r_stall_cnt;
    assign flush_cnt_o     = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl control outputs and
// counters; a second copy with 4-bit counters covers wrap-around.
module tb_pipe_ctrl;

    localparam logic [6:0] C_START = 7'b1000000;
    localparam logic [6:0] C_IFS   = 7'b0100000;
    localparam logic [6:0] C_IDS   = 7'b0010000;
    localparam logic [6:0] C_BUB   = 7'b0001000;
    localparam logic [6:0] C_IFF   = 7'b0000100;
    localparam logic [6:0] C_IDF   = 7'b0000010;
    localparam logic [6:0] C_WB    = 7'b0000001;
    localparam logic [6:0] C_STL   = C_IFS | C_IDS;

    logic        clk;
    logic        rst_n;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [3:0]  stall_cnt4;
    logic [3:0]  flush_cnt4;
    logic [6:0]  ctrl;
    logic [6:0]  ctrl4;
    int          n_chk;
    int          n_fail;
    int          exp_stall;
    int          exp_flush;

    pipe_ctrl_if bus ();
    pipe_ctrl_if bus4 ();

    pipe_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus4.slave),
        .stall_cnt_o (stall_cnt4),
        .flush_cnt_o (flush_cnt4)
    );

    assign bus4.id_valid_i      = bus.id_valid_i;
    assign bus4.id_rs1_en_i     = bus.id_rs1_en_i;
    assign bus4.id_rs2_en_i     = bus.id_rs2_en_i;
    assign bus4.id_rs1_idx_i    = bus.id_rs1_idx_i;
    assign bus4.id_rs2_idx_i    = bus.id_rs2_idx_i;
    assign bus4.ex_valid_i      = bus.ex_valid_i;
    assign bus4.ex_is_load_i    = bus.ex_is_load_i;
    assign bus4.ex_is_mdu_i     = bus.ex_is_mdu_i;
    assign bus4.ex_rd_idx_i     = bus.ex_rd_idx_i;
    assign bus4.ex_pipe_flush_i = bus.ex_pipe_flush_i;
    assign bus4.mdu_done_i      = bus.mdu_done_i;

    assign ctrl = {bus.mdu_start_o, bus.if_stall_o, bus.id_stall_o,
                   bus.ex_bubble_o, bus.if_flush_o, bus.id_flush_o,
                   bus.ex_mdu_wb_o};
    assign ctrl4 = {bus4.mdu_start_o, bus4.if_stall_o,
                    bus4.id_stall_o, bus4.ex_bubble_o,
                    bus4.if_flush_o, bus4.id_flush_o,
                    bus4.ex_mdu_wb_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl(input string tag, input logic [6:0] exp);
        #2;
        chk(tag, {25'd0, ctrl}, {25'd0, exp});
        chk({tag, "_w4"}, {25'd0, ctrl4}, {25'd0, exp});
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_stall"}, stall_cnt, exp_stall);
        chk({tag, "_flush"}, flush_cnt, exp_flush);
        chk({tag, "_stall4"}, {28'd0, stall_cnt4},
            {28'd0, 4'(exp_stall % 16)});
        chk({tag, "_flush4"}, {28'd0, flush_cnt4},
            {28'd0, 4'(exp_flush % 16)});
    endtask

    task automatic idle();
        bus.id_valid_i      = 1'b0;
        bus.id_rs1_en_i     = 1'b0;
        bus.id_rs2_en_i     = 1'b0;
        bus.id_rs1_idx_i    = '0;
        bus.id_rs2_idx_i    = '0;
        bus.ex_valid_i      = 1'b0;
        bus.ex_is_load_i    = 1'b0;
        bus.ex_is_mdu_i     = 1'b0;
        bus.ex_rd_idx_i     = '0;
        bus.ex_pipe_flush_i = 1'b0;
        bus.mdu_done_i      = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs2);
        idle();
        bus.ex_valid_i   = 1'b1;
        bus.ex_is_load_i = 1'b1;
        bus.ex_rd_idx_i  = rd;
        bus.id_valid_i   = 1'b1;
        bus.id_rs1_en_i  = 1'b1;
        bus.id_rs1_idx_i = 5'd3;
        bus.id_rs2_en_i  = 1'b1;
        bus.id_rs2_idx_i = rs2;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        exp_stall = 0;
        exp_flush = 0;
        rst_n     = 1'b0;
        idle();
        bus.ex_valid_i  = 1'b1;
        bus.ex_is_mdu_i = 1'b1;
        step();
        step();
        chk_ctrl("rst_ctrl", 7'd0);
        chk_cnt("rst");

        // First active cycle after release starts the MDU.
        rst_n = 1'b1;
        chk_ctrl("rel_start", C_START | C_STL);
        step();
        exp_stall++;
        bus.mdu_done_i = 1'b1;
        chk_ctrl("rel_done", C_WB);
        step();
        idle();
        chk_cnt("rel");

        // Load-use on rs2 with rd=5: one bubble cycle.
        load_use(5'd5, 5'd5);
        chk_ctrl("lu_hit", C_STL | C_BUB);
        step();
        exp_stall++;
        idle();
        chk_ctrl("lu_clear", 7'd0);
        chk_cnt("lu");

        // rd=0 never stalls.
        load_use(5'd0, 5'd0);
        chk_ctrl("lu_x0", 7'd0);
        step();
        // rs1 match with rs1 enabled.
        load_use(5'd3, 5'd9);
        chk_ctrl("lu_rs1", C_STL | C_BUB);
        step();
        exp_stall++;
        // rs1 match but ID not valid.
        load_use(5'd3, 5'd9);
        bus.id_valid_i = 1'b0;
        chk_ctrl("lu_idinv", 7'd0);
        step();
        chk_cnt("lu2");

        // Flush outranks load-use.
        load_use(5'd5, 5'd5);
        bus.ex_pipe_flush_i = 1'b1;
        chk_ctrl("flush_lu", C_IFF | C_IDF | C_BUB);
        step();
        exp_flush++;
        idle();
        chk_cnt("flush");

        // Flush outranks MDU start.
        bus.ex_valid_i      = 1'b1;
        bus.ex_is_mdu_i     = 1'b1;
        bus.ex_pipe_flush_i = 1'b1;
        chk_ctrl("flush_mdu", C_IFF | C_IDF | C_BUB);
        step();
        exp_flush++;
        idle();

        // MDU latency 33 with flush/load-use noise during the wait.
        bus.ex_valid_i  = 1'b1;
        bus.ex_is_mdu_i = 1'b1;
        bus.mdu_done_i  = 1'b1;
        chk_ctrl("mdu_T", C_START | C_STL);
        step();
        exp_stall++;
        bus.mdu_done_i      = 1'b0;
        bus.ex_pipe_flush_i = 1'b1;
        bus.ex_is_load_i    = 1'b1;
        bus.ex_rd_idx_i     = 5'd7;
        bus.id_valid_i      = 1'b1;
        bus.id_rs1_en_i     = 1'b1;
        bus.id_rs1_idx_i    = 5'd7;
        for (int i = 1; i <= 32; i++) begin
            chk_ctrl($sformatf("mdu_wait%0d", i), C_STL);
            step();
            exp_stall++;
        end
        bus.mdu_done_i = 1'b1;
        chk_ctrl("mdu_T33", C_WB);
        step();
        idle();
        chk_ctrl("mdu_after", 7'd0);
        chk_cnt("mdu");

        // Done pulse in the start cycle is ignored.
        bus.ex_valid_i  = 1'b1;
        bus.ex_is_mdu_i = 1'b1;
        bus.mdu_done_i  = 1'b1;
        chk_ctrl("early_T", C_START | C_STL);
        step();
        exp_stall++;
        chk_ctrl("early_T1", C_WB);
        step();
        idle();
        chk_cnt("early");

        // Reset in MDU_WAIT drops stalls immediately.
        bus.ex_valid_i  = 1'b1;
        bus.ex_is_mdu_i = 1'b1;
        step();
        idle();
        chk_ctrl("mid_wait", C_STL);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", {25'd0, ctrl}, 32'd0);
        exp_stall = 0;
        exp_flush = 0;
        chk_cnt("mid_rst");
        rst_n = 1'b1;
        step();
        bus.mdu_done_i = 1'b1;
        chk_ctrl("mid_run", 7'd0);
        step();
        idle();

        // 17 stall cycles: 4-bit counter wraps to 1.
        bus.ex_valid_i  = 1'b1;
        bus.ex_is_mdu_i = 1'b1;
        step();
        idle();
        exp_stall = 1;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_stall++;
        end
        bus.mdu_done_i = 1'b1;
        chk_ctrl("wrap_done", C_WB);
        step();
        idle();
        chk_cnt("wrap");
        chk("wrap_lit4", {28'd0, stall_cnt4}, 32'd1);
        chk("wrap_lit32", stall_cnt, 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control for the RV32 core: sequences the EX stage around multi-cycle multiply/divide operations, detects load-use hazards between ID and EX, and converts EX branch-mispredict flushes into per-stage stall, flush and bubble controls. It sits beside the IF/ID/EX pipeline registers and drives their enables. It also maintains free-running stall and flush performance counters.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `id_valid_i`  in  1  ID holds a valid instruction.
- `id_rs1_en_i`, `id_rs2_en_i`  in  1 each  ID instruction reads rs1 / rs2.
- `id_rs1_idx_i`, `id_rs2_idx_i`  in  `REG_IDX_WIDTH` each  ID source register indices.
- `ex_valid_i`  in  1  EX holds a valid instruction.
- `ex_is_load_i`  in  1  EX instruction is a load.
- `ex_is_mdu_i`  in  1  EX instruction is mul/div.
- `ex_rd_idx_i`  in  `REG_IDX_WIDTH`  EX destination register index.
- `ex_pipe_flush_i`  in  1  EX reports a branch mispredict.
- `mdu_done_i`  in  1  MDU result valid; single-cycle pulse.
- `mdu_start_o`  out  1  MDU start pulse.
- `if_stall_o`, `id_stall_o`  out  1 each  hold the IF / ID pipeline registers.
- `ex_bubble_o`  out  1  load a NOP into EX next cycle.
- `if_flush_o`, `id_flush_o`  out  1 each  invalidate the IF / ID contents.
- `ex_mdu_wb_o`  out  1  EX writes back the MDU result this cycle.
- `stall_cnt_o`, `flush_cnt_o`  out  `CNT_W` each  performance counters.

## Operation
State machine, 2 states, encoding `PCTL_RUN`=0, `PCTL_MDU_WAIT`=1.

Hazard terms:
- `lu_hit` = `ex_valid_i` & `ex_is_load_i` & (`ex_rd_idx_i` != 0) & `id_valid_i` & ((`id_rs1_en_i` & rs1 == rd) | (`id_rs2_en_i` & rs2 == rd)).
- `flush` = `ex_valid_i` & `ex_pipe_flush_i`.

RUN, evaluated in strict priority order:
1. `flush`: assert `if_flush_o`, `id_flush_o`, `ex_bubble_o`. No stall. Stay in RUN.
2. `ex_valid_i` & `ex_is_mdu_i`: assert `mdu_start_o`, `if_stall_o`, `id_stall_o`. Go to MDU_WAIT.
3. `lu_hit`: assert `if_stall_o`, `id_stall_o`, `ex_bubble_o` for exactly one cycle. Stay in RUN. The hazard clears by itself because EX then holds the bubble.
4. Otherwise all controls are 0.

MDU_WAIT (EX holds the MDU instruction):
- `mdu_done_i`=0: `if_stall_o`, `id_stall_o` = 1. Stay.
- `mdu_done_i`=1: `ex_mdu_wb_o`=1, stalls = 0, go to RUN.
- `ex_pipe_flush_i` and `lu_hit` are ignored in MDU_WAIT.
- `mdu_done_i` is ignored in RUN, including a done pulse in the same cycle as `mdu_start_o`.

Counters:
- `stall_cnt_o` increments on each cycle with `if_stall_o`=1.
- `flush_cnt_o` increments on each cycle with `if_flush_o`=1.
- Both wrap modulo 2^`CNT_W`.

All control outputs are combinational from state and inputs. No control output may combinationally depend on `mdu_start_o`.

## Timing
- Reset (`rst_n`=0, asynchronous): state RUN, counters 0. All control outputs evaluate to 0 while held in reset. Reset mid-MDU_WAIT returns to RUN. The MDU is reset by the same `rst_n`.
- Load-use penalty: 1 cycle.
- Mispredict: flush asserted in the same cycle as `ex_pipe_flush_i`, 0 stall cycles.
- MDU: `mdu_start_o` is asserted in cycle T. The earliest accepted `mdu_done_i` is in T+1. Stall cycles = (done cycle − T). IF and ID advance in the cycle `ex_mdu_wb_o`=1.
- A state transition takes effect on the `clk` rising edge. Counters update on the same edge.

## Structure
- The state encodings `PCTL_RUN` / `PCTL_MDU_WAIT` go in `defines.v`. Widths come from the existing `REG_IDX_WIDTH` define.
- One sub-module, `pctl_hazard`: the combinational load-use comparator producing `lu_hit`.
- The counters are inline.

## Test plan
- Reset: hold `rst_n`=0 with `ex_is_mdu_i`=1. Required: all outputs 0 and counters 0. Release: `mdu_start_o`=1 on the first active cycle.
- Load-use: EX `lw x5` (`ex_rd_idx_i`=5), ID reads rs2=5. Required: stalls and `ex_bubble_o` = 1 for 1 cycle, `stall_cnt_o`=1. Repeat with rd=0: no stall.
- Flush vs load-use: `ex_pipe_flush_i`=1 and `lu_hit` true in the same cycle. Required: `if_flush_o`=`id_flush_o`=`ex_bubble_o`=1, stalls 0, `flush_cnt_o`=1.
- MDU latency: start at T, `mdu_done_i` at T+33. Required: stalls high during T..T+32, `ex_mdu_wb_o`=1 at T+33, `stall_cnt_o`=33.
- MDU done in the start cycle: `mdu_done_i`=1 at T. Required: ignored, FSM waits for the done at T+1, `ex_mdu_wb_o`=1 at T+1.
- Reset mid-wait and wrap: assert `rst_n`=0 in MDU_WAIT. Required: state RUN and stalls drop immediately. With `CNT_W`=4, 17 stall cycles give `stall_cnt_o`=1.
